// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// controller state and the destination-register scoreboard entry.
package pipe_pkg;

  localparam int RF_IDX_W = 4;
  localparam int PC_REG   = 15;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic                valid;
    logic [RF_IDX_W-1:0] rd;
    logic                is_load;
  } sb_entry_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode-side hazard inputs and pipeline sequencing outputs of the hazard controller.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 4
) ();
  logic [REG_W-1:0] id_rn;
  logic [REG_W-1:0] id_rm;
  logic [REG_W-1:0] id_rs;
  logic             id_use_rn;
  logic             id_use_rm;
  logic             id_use_rs;
  logic [REG_W-1:0] id_rd;
  logic             id_rf_enable;
  logic             id_load;
  logic             ex_branch_taken;
  logic             mem_busy;
  logic             pc_enable;
  logic             if_id_enable;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_enable;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [1:0]       fwd_s;
  logic             mem_error;
  logic [15:0]      stall_count;

  modport master (
    output id_rn, id_rm, id_rs, id_use_rn, id_use_rm, id_use_rs,
           id_rd, id_rf_enable, id_load, ex_branch_taken, mem_busy,
    input  pc_enable, if_id_enable, if_id_flush, id_ex_flush, ex_mem_enable,
           fwd_a, fwd_b, fwd_s, mem_error, stall_count
  );

  modport slave (
    input  id_rn, id_rm, id_rs, id_use_rn, id_use_rm, id_use_rs,
           id_rd, id_rf_enable, id_load, ex_branch_taken, mem_busy,
    output pc_enable, if_id_enable, if_id_flush, id_ex_flush, ex_mem_enable,
           fwd_a, fwd_b, fwd_s, mem_error, stall_count
  );
endinterface

// File: rtl/fwd_select.sv
// Forwarding source for one ID operand: youngest matching producer wins,
// loads in EX are skipped because their data is not ready yet.
module fwd_select
  import pipe_pkg::*;
#(
  parameter int REG_W = RF_IDX_W
) (
  input  logic             i_use,
  input  logic [REG_W-1:0] i_reg,
  input  sb_entry_t        i_ex,
  input  sb_entry_t        i_mem,
  input  sb_entry_t        i_wb,
  output fwd_sel_t         o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (i_use && (i_reg != REG_W'(PC_REG))) begin
      if (i_ex.valid && !i_ex.is_load && (i_ex.rd == i_reg)) o_sel = FWD_EX;
      else if (i_mem.valid && (i_mem.rd == i_reg))           o_sel = FWD_MEM;
      else if (i_wb.valid && (i_wb.rd == i_reg))             o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage core: scoreboard, load-use stall, branch flush,
// forwarding selects and a data-memory freeze with watchdog.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_W       = RF_IDX_W,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  pipeline_hazard_ctrl_if.slave   hz
);

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  sb_entry_t   r_ex, r_mem, r_wb;
  hz_state_t   r_state;
  logic [7:0]  r_wait;
  logic        r_mem_error;
  logic [15:0] r_stall_cnt;

  sb_entry_t   w_new;
  logic        w_load_use;
  logic        w_pc_en, w_ifid_en, w_ifid_flush, w_idex_flush, w_exmem_en;
  logic [7:0]  w_wait_nxt;
  fwd_sel_t    w_fwd_a, w_fwd_b, w_fwd_s;

  assign w_new = '{valid:   hz.id_rf_enable && (hz.id_rd != REG_W'(PC_REG)),
                   rd:      hz.id_rd,
                   is_load: hz.id_load};

  // r15 never reaches a valid entry, so a match here already excludes it
  assign w_load_use = r_ex.valid && r_ex.is_load &&
                      ((hz.id_use_rn && (hz.id_rn == r_ex.rd)) ||
                       (hz.id_use_rm && (hz.id_rm == r_ex.rd)) ||
                       (hz.id_use_rs && (hz.id_rs == r_ex.rd)));

  always_comb begin
    w_pc_en      = 1'b1;
    w_ifid_en    = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_exmem_en   = 1'b1;
    if (reset) begin
      if (hz.mem_busy) begin
        w_pc_en    = 1'b0;
        w_ifid_en  = 1'b0;
        w_exmem_en = 1'b0;
      end else if (hz.ex_branch_taken) begin
        w_ifid_flush = 1'b1;
        w_idex_flush = 1'b1;
      end else if (w_load_use) begin
        w_pc_en      = 1'b0;
        w_ifid_en    = 1'b0;
        w_idex_flush = 1'b1;
      end
    end
  end

  assign w_wait_nxt = (r_state == RUN)   ? 8'd1 :
                      (r_wait >= TIMEOUT) ? r_wait : r_wait + 8'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= RUN;
      r_wait      <= '0;
      r_mem_error <= 1'b0;
      r_stall_cnt <= '0;
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
    end else begin
      if (!w_pc_en && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (hz.mem_busy) begin
        r_state <= MEM_WAIT;
        r_wait  <= w_wait_nxt;
        if (w_wait_nxt == TIMEOUT) r_mem_error <= 1'b1;
      end else begin
        // Leaving the freeze evaluates this cycle as RUN
        r_state <= RUN;
        r_wait  <= '0;
        r_wb    <= r_mem;
        r_mem   <= r_ex;
        r_ex    <= (hz.ex_branch_taken || w_load_use) ? '0 : w_new;
      end
    end
  end

  fwd_select #(.REG_W(REG_W)) u_fwd_a (
    .i_use(hz.id_use_rn), .i_reg(hz.id_rn),
    .i_ex(r_ex), .i_mem(r_mem), .i_wb(r_wb), .o_sel(w_fwd_a)
  );
  fwd_select #(.REG_W(REG_W)) u_fwd_b (
    .i_use(hz.id_use_rm), .i_reg(hz.id_rm),
    .i_ex(r_ex), .i_mem(r_mem), .i_wb(r_wb), .o_sel(w_fwd_b)
  );
  fwd_select #(.REG_W(REG_W)) u_fwd_s (
    .i_use(hz.id_use_rs), .i_reg(hz.id_rs),
    .i_ex(r_ex), .i_mem(r_mem), .i_wb(r_wb), .o_sel(w_fwd_s)
  );

  assign hz.pc_enable     = w_pc_en;
  assign hz.if_id_enable  = w_ifid_en;
  assign hz.if_id_flush   = w_ifid_flush;
  assign hz.id_ex_flush   = w_idex_flush;
  assign hz.ex_mem_enable = w_exmem_en;
  assign hz.fwd_a         = w_fwd_a;
  assign hz.fwd_b         = w_fwd_b;
  assign hz.fwd_s         = w_fwd_s;
  assign hz.mem_error     = r_mem_error;
  assign hz.stall_count   = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: per-cycle vector table plus
// hand-written freeze, timeout and reset sequences.
module tb_pipeline_hazard_ctrl;

  localparam int MT = 5;
  // {pc_enable, if_id_enable, if_id_flush, id_ex_flush, ex_mem_enable}
  localparam logic [4:0] N  = 5'b11001;
  localparam logic [4:0] LU = 5'b00011;
  localparam logic [4:0] BR = 5'b11111;
  localparam logic [4:0] FZ = 5'b00000;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_W(4)) ifc ();

  pipeline_hazard_ctrl #(.REG_W(4), .MEM_TIMEOUT(MT)) dut (
    .clk   (clk),
    .reset (rst_n),
    .hz    (ifc)
  );

  typedef struct {
    logic [3:0]  rn, rm, rs;
    logic [2:0]  u;
    logic [3:0]  rd;
    logic        rfe, ld, br;
    logic [4:0]  ctl;
    logic [1:0]  fa, fb, fs;
    logic [15:0] sc;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(input logic [3:0] rn, rm, rs, input logic [2:0] u,
                              input logic [3:0] rd, input logic rfe, ld, br,
                              input logic [4:0] ctl, input logic [1:0] fa, fb, fs,
                              input logic [15:0] sc);
    vec_t v;
    v.rn = rn; v.rm = rm; v.rs = rs; v.u = u; v.rd = rd;
    v.rfe = rfe; v.ld = ld; v.br = br;
    v.ctl = ctl; v.fa = fa; v.fb = fb; v.fs = fs; v.sc = sc;
    return v;
  endfunction

  task automatic drive(input logic [3:0] rn, rm, rs, input logic [2:0] u,
                       input logic [3:0] rd, input logic rfe, ld, br, busy);
    ifc.id_rn = rn; ifc.id_rm = rm; ifc.id_rs = rs;
    {ifc.id_use_rn, ifc.id_use_rm, ifc.id_use_rs} = u;
    ifc.id_rd = rd; ifc.id_rf_enable = rfe; ifc.id_load = ld;
    ifc.ex_branch_taken = br; ifc.mem_busy = busy;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {ifc.pc_enable, ifc.if_id_enable, ifc.if_id_flush, ifc.id_ex_flush,
            ifc.ex_mem_enable, ifc.fwd_a, ifc.fwd_b, ifc.fwd_s};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    //                rn rm rs  u     rd rfe ld br  ctl fa fb fs sc
    tbl[0]  = mk(4'd2, 4'd3, 4'd0, 3'b110, 4'd1, 1, 0, 0, N,  0, 0, 0, 0);
    tbl[1]  = mk(4'd1, 4'd3, 4'd0, 3'b110, 4'd2, 1, 0, 0, N,  1, 0, 0, 0);
    tbl[2]  = mk(4'd1, 4'd0, 4'd0, 3'b100, 4'd6, 1, 0, 0, N,  2, 0, 0, 0);
    tbl[3]  = mk(4'd0, 4'd1, 4'd2, 3'b011, 4'd7, 1, 0, 0, N,  0, 3, 2, 0);
    tbl[4]  = mk(4'd1, 4'd7, 4'd6, 3'b111, 4'd0, 0, 0, 0, N,  0, 1, 2, 0);
    tbl[5]  = mk(4'd6, 4'd7, 4'd0, 3'b110, 4'd0, 0, 0, 0, N,  3, 2, 0, 0);
    tbl[6]  = mk(4'd7, 4'd0, 4'd0, 3'b100, 4'd4, 1, 1, 0, N,  3, 0, 0, 0);
    tbl[7]  = mk(4'd4, 4'd4, 4'd0, 3'b110, 4'd5, 1, 0, 0, LU, 0, 0, 0, 0);
    tbl[8]  = mk(4'd4, 4'd4, 4'd0, 3'b110, 4'd5, 1, 0, 0, N,  2, 2, 0, 1);
    tbl[9]  = mk(4'd0, 4'd0, 4'd0, 3'b000, 4'd8, 1, 1, 0, N,  0, 0, 0, 1);
    tbl[10] = mk(4'd8, 4'd5, 4'd0, 3'b110, 4'd9, 1, 0, 1, BR, 0, 2, 0, 1);
    tbl[11] = mk(4'd5, 4'd8, 4'd0, 3'b110, 4'd0, 0, 0, 0, N,  3, 2, 0, 1);
    tbl[12] = mk(4'd15, 4'd15, 4'd15, 3'b111, 4'd15, 1, 1, 0, N, 0, 0, 0, 1);
    tbl[13] = mk(4'd15, 4'd15, 4'd15, 3'b111, 4'd3, 1, 0, 0, N,  0, 0, 0, 1);
    tbl[14] = mk(4'd3, 4'd15, 4'd3, 3'b110, 4'd0, 0, 0, 0, N,  1, 0, 0, 1);

    // Reset state: busy/branch/used sources must not leak through while in reset
    rst_n = 1'b0;
    drive(4'd1, 4'd1, 4'd1, 3'b111, 4'd1, 1, 1, 1, 1);
    #3;
    check("reset_outs", 32'(outs()), 32'({N, 6'd0}));
    check("reset_err", 32'(ifc.mem_error), 32'd0);
    check("reset_sc", 32'(ifc.stall_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    drive(4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rn, tbl[i].rm, tbl[i].rs, tbl[i].u, tbl[i].rd,
            tbl[i].rfe, tbl[i].ld, tbl[i].br, 1'b0);
      @(negedge clk);
      check($sformatf("row%0d_outs", i), 32'(outs()),
            32'({tbl[i].ctl, tbl[i].fa, tbl[i].fb, tbl[i].fs}));
      check($sformatf("row%0d_sc", i), 32'(ifc.stall_count), 32'(tbl[i].sc));
      @(posedge clk);
      #1;
    end

    // Freeze for 3 cycles with a pending branch; r9 stays in EX throughout
    drive(4'd0, 4'd0, 4'd0, 3'b000, 4'd9, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      drive(4'd9, 4'd3, 4'd0, 3'b110, 4'd10, 1, 0, 1, 1);
      @(negedge clk);
      check($sformatf("freeze%0d_outs", k), 32'(outs()), 32'({FZ, 2'd1, 2'd3, 2'd0}));
      @(posedge clk);
      #1;
    end
    drive(4'd9, 4'd3, 4'd0, 3'b110, 4'd10, 1, 0, 1, 0);
    @(negedge clk);
    check("release_branch_outs", 32'(outs()), 32'({BR, 2'd1, 2'd3, 2'd0}));
    check("freeze_sc", 32'(ifc.stall_count), 32'd4);
    @(posedge clk);
    #1;
    drive(4'd9, 4'd3, 4'd0, 3'b110, 4'd0, 0, 0, 0, 0);
    @(negedge clk);
    check("after_branch_outs", 32'(outs()), 32'({N, 2'd2, 2'd0, 2'd0}));
    @(posedge clk);
    #1;

    // Watchdog: busy for MT+2 cycles
    for (int i = 1; i <= MT + 2; i++) begin
      drive(4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 0, 0, 0, 1);
      @(negedge clk);
      check($sformatf("busy%0d_ctl_err", i), 32'({outs(), ifc.mem_error}),
            32'({FZ, 6'd0, (i > MT) ? 1'b1 : 1'b0}));
      @(posedge clk);
      #1;
    end
    drive(4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 0, 0, 0, 0);
    @(negedge clk);
    check("post_busy_ctl_err", 32'({outs(), ifc.mem_error}), 32'({N, 6'd0, 1'b1}));
    check("post_busy_sc", 32'(ifc.stall_count), 32'(4 + MT + 2));
    @(posedge clk);
    @(negedge clk);
    check("err_sticky", 32'(ifc.mem_error), 32'd1);
    rst_n = 1'b0;
    #1;
    check("err_reset", 32'(ifc.mem_error), 32'd0);
    check("sc_reset", 32'(ifc.stall_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset asserted in the middle of a load-use stall
    drive(4'd0, 4'd0, 4'd0, 3'b000, 4'd4, 1, 1, 0, 0);
    @(posedge clk);
    #1;
    drive(4'd4, 4'd4, 4'd0, 3'b110, 4'd5, 1, 0, 0, 0);
    @(negedge clk);
    check("lu_before_reset", 32'(outs()), 32'({LU, 6'd0}));
    #2;
    rst_n = 1'b0;
    #1;
    check("lu_in_reset", 32'(outs()), 32'({N, 6'd0}));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("lu_after_reset", 32'(outs()), 32'({N, 6'd0}));
    check("lu_after_reset_sc", 32'(ifc.stall_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences the IF/ID and ID/EX pipeline registers and the PC for the 5-stage core.
- Keeps its own destination-register scoreboard for EX, MEM and WB, and generates:
  - stalls and bubble insertion (load-use hazards),
  - flushes (taken branches resolved in EX),
  - operand forwarding selects.
- Freezes the whole pipeline while data memory is busy, with a watchdog timeout.

Parameters:
- REG_W, 4, register-index width
- MEM_TIMEOUT, 64, max consecutive mem_busy cycles before mem_error; range 2..255

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- id_rn  in  REG_W  ID operand A source register
- id_rm  in  REG_W  ID operand B source register
- id_rs  in  REG_W  ID store-data source register
- id_use_rn, id_use_rm, id_use_rs  in  1 each  source actually read
- id_rd  in  REG_W  ID destination register
- id_rf_enable  in  1  ID instruction writes register file
- id_load  in  1  ID instruction is a load
- ex_branch_taken  in  1  branch/BL taken, resolved in EX
- mem_busy  in  1  data memory access not complete
- pc_enable  out  1  PC may update
- if_id_enable  out  1  IF/ID register may load
- if_id_flush  out  1  IF/ID loads NOP
- id_ex_flush  out  1  ID/EX loads all-zero control (bubble)
- ex_mem_enable  out  1  EX/MEM and MEM/WB may load
- fwd_a, fwd_b, fwd_s  out  2 each  00=RF, 01=EX result, 10=MEM result, 11=WB result
- mem_error  out  1  sticky watchdog flag
- stall_count  out  16  saturating count of stall/freeze cycles

Behaviour:
- Reset (reset=0, asynchronous):
  - scoreboard valid bits cleared, FSM=RUN, mem_error=0, stall_count=0, wait counter=0.
  - Outputs while in reset: pc_enable=1, if_id_enable=1, ex_mem_enable=1, all flushes 0, all fwd 00.
- Scoreboard entries EX, MEM, WB each hold {valid, rd, is_load}.
  - An entry is valid only if it writes a register and rd != 15.
- Forwarding (combinational, same cycle), per operand:
  - Operand not used, or register == 15 -> 00.
  - Otherwise the first match in priority order: EX (valid, not load) -> 01; MEM -> 10; WB -> 11; none -> 00.
- Load-use hazard: EX.valid & EX.is_load & EX.rd matches any used ID source (excluding r15).
- FSM states: RUN, MEM_WAIT. Priority each cycle: mem_busy > ex_branch_taken > load-use > normal.
- RUN with mem_busy=1:
  - Freeze: pc_enable, if_id_enable and ex_mem_enable all 0; no flushes.
  - Scoreboard holds; go to MEM_WAIT with wait counter=1.
  - ex_branch_taken and the load-use check are ignored this cycle. The branch is acted on after the freeze because EX is held.
- RUN with ex_branch_taken:
  - if_id_flush=1, id_ex_flush=1, PC loads the target.
  - Scoreboard shift: WB<=MEM, MEM<=EX, EX<=empty.
- RUN with load-use:
  - pc_enable=0, if_id_enable=0, id_ex_flush=1.
  - Scoreboard shift: EX<=empty, MEM<=EX, WB<=MEM.
  - Exactly one bubble; the next cycle forwards from MEM (10).
- RUN, normal: all enables 1; scoreboard shift with EX<={id_rf_enable, id_rd, id_load}.
- MEM_WAIT:
  - Stays frozen while mem_busy=1, incrementing the wait counter.
  - Counter reaching MEM_TIMEOUT sets mem_error=1 (sticky until reset) and the FSM stays frozen.
  - mem_busy=0 -> RUN, and the same cycle is evaluated with RUN rules.
- stall_count increments on every cycle where pc_enable=0 and saturates at 0xFFFF.
- Reset mid-stall or mid-freeze: immediate return to reset values; no partial shift.

Decomposition:
- Package pipe_pkg holds:
  - fwd_sel_t (FWD_RF, FWD_EX, FWD_MEM, FWD_WB),
  - hz_state_t (RUN, MEM_WAIT),
  - sb_entry_t struct,
  - constant PC_REG=15.
- Sub-module fwd_select: one operand's priority match, instantiated three times (fwd_a, fwd_b, fwd_s).

Test Plan:
- ADD r1 then SUB r2,r1,r3: cycle 2 -> fwd_a=01, no stall; one instruction later a reader of r1 -> fwd 10; two later -> 11.
- LDR r4 then ADD r5,r4,r4: one cycle with pc_enable=0, id_ex_flush=1, stall_count=1; next cycle fwd_a=fwd_b=10.
- ex_branch_taken=1 while a load-use condition also holds: if_id_flush=id_ex_flush=1, pc_enable=1, no stall.
- mem_busy held 3 cycles: all enables 0 for 3 cycles, scoreboard unchanged, stall_count=3, RUN on release.
- mem_busy held for MEM_TIMEOUT+2 cycles: mem_error=1 from cycle MEM_TIMEOUT, and stays 1 after mem_busy drops; reset clears it.
- Source/destination r15 for every operand: fwd always 00, never stalls; reset asserted during a load-use stall -> enables=1 immediately.
